// File: rtl/iobus_pkg.sv
// Shared types and MMIO address map for the IOBUS arbiter.
// Widths here match the default ADDR_W/DATA_W of the top level.
package iobus_pkg;

   localparam int IOBUS_W = 32;

   localparam logic [IOBUS_W-1:0] SWITCHES_AD = 32'h11000000;
   localparam logic [IOBUS_W-1:0] LEDS_AD     = 32'h11000020;
   localparam logic [IOBUS_W-1:0] SSEG_AD     = 32'h11000040;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } iobus_state_t;

   typedef struct packed {
      logic               wr;
      logic [IOBUS_W-1:0] addr;
      logic [IOBUS_W-1:0] wdata;
   } iobus_req_t;

   // One-hot select for a 2-port owner index.
   function automatic logic [1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/iobus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the port
// that did not win the previous grant.
module rr_arb2
   import iobus_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   logic last_q;

   // Pick the single requester, or the non-last one on a tie
   always_comb begin
      grant_o = 2'b00;
      unique case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = owner_onehot(~last_q);
         default: grant_o = 2'b00;
      endcase
   end

   // Remember who won; reset favours port 0 on the first tie
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else if (advance_i && (|req_i)) begin
         last_q <= grant_o[1];
      end
   end

endmodule

// File: rtl/iobus_arbiter.sv
// Shares the MMIO IOBUS between the CPU (port 0) and an
// auxiliary master (port 1); one 3-cycle transaction at a time.
module iobus_arbiter
   import iobus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ0,
   input  logic              WR0,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [DATA_W-1:0] WDATA0,
   output logic              GNT0,
   output logic              DONE0,
   input  logic              REQ1,
   input  logic              WR1,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] WDATA1,
   output logic              GNT1,
   output logic              DONE1,
   output logic [DATA_W-1:0] RDATA,
   output logic [ADDR_W-1:0] IOBUS_ADDR,
   output logic [DATA_W-1:0] IOBUS_OUT,
   output logic              IOBUS_WR,
   input  logic [DATA_W-1:0] IOBUS_IN,
   output logic              BUSY,
   output logic [CNT_W-1:0]  XFER_CNT
);

   iobus_state_t      state_q;
   logic              owner_q;
   logic [1:0]        gnt_q;
   logic [1:0]        done_q;
   logic              busy_q;
   logic              iobus_wr_q;
   logic [ADDR_W-1:0] iobus_addr_q;
   logic [DATA_W-1:0] iobus_out_q;
   logic [DATA_W-1:0] rdata_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              advance;
   logic              wr_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;

   assign req     = {REQ1, REQ0};
   assign advance = (state_q == IDLE);

   rr_arb2 u_arb (
      .clk_i     (CLK),
      .rst_i     (RST),
      .req_i     (req),
      .advance_i (advance),
      .grant_o   (grant)
   );

   // Route the winning requester's command toward the latches
   always_comb begin
      wr_d    = WR0;
      addr_d  = ADDR0;
      wdata_d = WDATA0;
      if (grant[1]) begin
         wr_d    = WR1;
         addr_d  = ADDR1;
         wdata_d = WDATA1;
      end
   end

   // Sequencer: latch in IDLE, drive bus in XFER, complete in RESP
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         gnt_q        <= 2'b00;
         done_q       <= 2'b00;
         busy_q       <= 1'b0;
         iobus_wr_q   <= 1'b0;
         iobus_addr_q <= '0;
         iobus_out_q  <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
      end else begin
         gnt_q        <= 2'b00;
         done_q       <= 2'b00;
         iobus_wr_q   <= 1'b0;
         iobus_addr_q <= '0;
         iobus_out_q  <= '0;
         unique case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (|grant) begin
                  state_q      <= XFER;
                  owner_q      <= grant[1];
                  gnt_q        <= grant;
                  busy_q       <= 1'b1;
                  iobus_wr_q   <= wr_d;
                  iobus_addr_q <= addr_d;
                  iobus_out_q  <= wdata_d;
               end
            end
            XFER: begin
               if (!iobus_wr_q) begin
                  rdata_q <= IOBUS_IN;
               end
               done_q  <= owner_onehot(owner_q);
               cnt_q   <= cnt_q + 1'b1;
               state_q <= RESP;
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign GNT0       = gnt_q[0];
   assign GNT1       = gnt_q[1];
   assign DONE0      = done_q[0];
   assign DONE1      = done_q[1];
   assign BUSY       = busy_q;
   assign IOBUS_WR   = iobus_wr_q;
   assign IOBUS_ADDR = iobus_addr_q;
   assign IOBUS_OUT  = iobus_out_q;
   assign RDATA      = rdata_q;
   assign XFER_CNT   = cnt_q;

endmodule

// File: tb/tb_iobus_arbiter.sv
// Directed bench for iobus_arbiter; counter is narrowed
// to 4 bits so the wrap case stays short.
module tb_iobus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, wr0, req1, wr1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        gnt0, done0, gnt1, done1;
   logic [31:0] rdata, bus_addr, bus_out, bus_in;
   logic        bus_wr, busy;
   logic [3:0]  xcnt;

   int n_chk = 0;
   int n_err = 0;

   iobus_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .CNT_W  (4)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .REQ0       (req0),
      .WR0        (wr0),
      .ADDR0      (addr0),
      .WDATA0     (wdata0),
      .GNT0       (gnt0),
      .DONE0      (done0),
      .REQ1       (req1),
      .WR1        (wr1),
      .ADDR1      (addr1),
      .WDATA1     (wdata1),
      .GNT1       (gnt1),
      .DONE1      (done1),
      .RDATA      (rdata),
      .IOBUS_ADDR (bus_addr),
      .IOBUS_OUT  (bus_out),
      .IOBUS_WR   (bus_wr),
      .IOBUS_IN   (bus_in),
      .BUSY       (busy),
      .XFER_CNT   (xcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are looked at 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req0 = 0; wr0 = 0; req1 = 0; wr1 = 0;
      addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0;
      bus_in = '0;
      do_reset();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(xcnt), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_wr", 32'(bus_wr), 32'd0);
      chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);

      // single write from port 0
      req0 = 1; wr0 = 1; addr0 = 32'h11000020; wdata0 = 32'h0000A5A5;
      chk("w_c0_wr", 32'(bus_wr), 32'd0);
      step();
      chk("w_c1_gnt", 32'({gnt1, gnt0}), 32'b01);
      chk("w_c1_wr", 32'(bus_wr), 32'd1);
      chk("w_c1_addr", bus_addr, 32'h11000020);
      chk("w_c1_out", bus_out, 32'h0000A5A5);
      chk("w_c1_busy", 32'(busy), 32'd1);
      step();
      chk("w_c2_done", 32'({done1, done0}), 32'b01);
      chk("w_c2_cnt", 32'(xcnt), 32'd1);
      chk("w_c2_wr", 32'(bus_wr), 32'd0);
      chk("w_c2_addr", bus_addr, 32'd0);
      req0 = 0;
      step();
      chk("w_c3_done", 32'({done1, done0}), 32'b00);
      chk("w_c3_busy", 32'(busy), 32'd0);
      step();
      chk("w_c4_busy", 32'(busy), 32'd0);
      chk("w_c4_wr", 32'(bus_wr), 32'd0);

      // single read from port 1
      req1 = 1; wr1 = 0; addr1 = 32'h11000000; bus_in = 32'h0000BEEF;
      step();
      chk("r_c1_gnt", 32'({gnt1, gnt0}), 32'b10);
      chk("r_c1_wr", 32'(bus_wr), 32'd0);
      chk("r_c1_addr", bus_addr, 32'h11000000);
      step();
      chk("r_c2_done", 32'({done1, done0}), 32'b10);
      chk("r_c2_rdata", rdata, 32'h0000BEEF);
      chk("r_c2_cnt", 32'(xcnt), 32'd2);
      req1 = 0; bus_in = 32'h0;
      repeat (10) step();
      chk("r_hold", rdata, 32'h0000BEEF);

      // both held after reset: 0,1,0,1
      do_reset();
      req0 = 1; wr0 = 1; addr0 = 32'h11000020; wdata0 = 32'h00000A0A;
      req1 = 1; wr1 = 1; addr1 = 32'h11000040; wdata1 = 32'h00000B0B;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rr_gnt", 32'({gnt1, gnt0}), (k % 2 == 0) ? 32'b01 : 32'b10);
         chk("rr_out", bus_out,
             (k % 2 == 0) ? 32'h00000A0A : 32'h00000B0B);
         step();
         chk("rr_done", 32'({done1, done0}),
             (k % 2 == 0) ? 32'b01 : 32'b10);
         chk("rr_cnt", 32'(xcnt), 32'(k + 1));
         if (k == 3) begin
            req0 = 0; req1 = 0;
         end
         step();
         chk("rr_idle", 32'(busy), 32'd0);
      end
      step();
      chk("rr_end_busy", 32'(busy), 32'd0);
      chk("rr_end_cnt", 32'(xcnt), 32'd4);

      // command change after grant is ignored
      req0 = 1; wr0 = 1; addr0 = 32'h11000040; wdata0 = 32'h00000111;
      step();
      addr0 = 32'h11000020; wdata0 = 32'h00000222;
      #2;
      chk("late_addr", bus_addr, 32'h11000040);
      chk("late_out", bus_out, 32'h00000111);
      step();
      chk("late_done", 32'({done1, done0}), 32'b01);
      req0 = 0;
      step();

      // reset during XFER aborts without DONE
      req1 = 1; wr1 = 1; addr1 = 32'h11000020; wdata1 = 32'h00000077;
      step();
      chk("ab_gnt", 32'({gnt1, gnt0}), 32'b10);
      chk("ab_wr", 32'(bus_wr), 32'd1);
      rst = 1; req1 = 0;
      step();
      rst = 0;
      chk("ab_done", 32'({done1, done0}), 32'b00);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_buswr", 32'(bus_wr), 32'd0);
      step();
      chk("ab_done2", 32'({done1, done0}), 32'b00);
      chk("ab_cnt", 32'(xcnt), 32'd0);

      // reset during RESP of a port-1 read
      req1 = 1; wr1 = 0; addr1 = 32'h11000000; bus_in = 32'h00001234;
      step();
      step();
      chk("rs_done", 32'({done1, done0}), 32'b10);
      chk("rs_rdata", rdata, 32'h00001234);
      rst = 1; req1 = 0;
      step();
      rst = 0;
      chk("rs_done_after", 32'({done1, done0}), 32'b00);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_cnt", 32'(xcnt), 32'd0);
      chk("rs_rdata0", rdata, 32'd0);
      req0 = 1; wr0 = 0; req1 = 1; wr1 = 0;
      step();
      chk("rs_tie", 32'({gnt1, gnt0}), 32'b01);
      step();
      chk("rs_tie_done", 32'({done1, done0}), 32'b01);
      req0 = 0;
      step();
      step();
      chk("rs_next", 32'({gnt1, gnt0}), 32'b10);
      step();
      req1 = 0;
      step();

      // 4-bit counter wraps after 16 transactions
      do_reset();
      for (int i = 0; i < 16; i++) begin
         req0 = 1; wr0 = 1; addr0 = 32'h11000020; wdata0 = 32'(i);
         step();
         step();
         chk("wrap_cnt", 32'(xcnt), 32'((i + 1) % 16));
         req0 = 0;
         step();
      end
      chk("wrap_final", 32'(xcnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/iobus_arbiter.md
Name: iobus_arbiter

Overview:
Shares the single MMIO IOBUS (address/out/in/write strobe) between two requesters: port 0 (OTTER_MCU) and port 1 (auxiliary master, e.g. a debug loader or DMA engine). Each transaction is arbitrated round-robin, latched, driven onto the IOBUS for exactly one cycle, then completed with a DONE pulse and returned read data. It sits between the CPU and the peripheral decode logic (switch input mux, LED/SSEG output registers) and runs on the 50 MHz CPU clock.

Parameters:
ADDR_W, 32, IOBUS address width
DATA_W, 32, IOBUS data width
CNT_W, 16, width of the completed-transaction counter

Ports:
CLK  in  1  system clock (50 MHz CPU clock); all logic on posedge
RST  in  1  reset; synchronous, active-high
REQ0  in  1  requester 0 transaction request
WR0  in  1  requester 0: 1 = write, 0 = read
ADDR0  in  ADDR_W  requester 0 address
WDATA0  in  DATA_W  requester 0 write data
GNT0  out  1  requester 0 owns the bus (XFER state)
DONE0  out  1  one-cycle completion pulse to requester 0
REQ1, WR1, ADDR1, WDATA1, GNT1, DONE1  same as above, for requester 1
RDATA  out  DATA_W  read data of the last completed read; valid with DONEx
IOBUS_ADDR  out  ADDR_W  bus address to peripherals
IOBUS_OUT  out  DATA_W  bus write data to peripherals
IOBUS_WR  out  1  bus write strobe
IOBUS_IN  in  DATA_W  combinational read data from the peripheral mux
BUSY  out  1  high whenever state is not IDLE
XFER_CNT  out  CNT_W  count of completed transactions

Behaviour:
- States: IDLE, XFER, RESP. Each transaction takes 3 cycles: IDLE (arbitrate) -> XFER -> RESP -> IDLE.
- IDLE: if any REQx is high, select the owner, latch WRx/ADDRx/WDATAx into internal registers, and go to XFER. Otherwise stay in IDLE.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester not recorded in last_owner wins.
  - last_owner updates when a request is granted.
- XFER:
  - GNTx = 1 for the owner only.
  - IOBUS_ADDR and IOBUS_OUT come from the latched registers.
  - IOBUS_WR = latched WR, high for exactly this one cycle.
  - For a read, IOBUS_IN is captured into RDATA at the end of XFER.
  - For a write, RDATA is unchanged.
- RESP: DONEx = 1 for the owner for one cycle. XFER_CNT increments, wrapping to 0 at 2^CNT_W. Next state is IDLE unconditionally.
- Outside XFER: IOBUS_WR = 0, IOBUS_ADDR = 0, IOBUS_OUT = 0. This guarantees no stray peripheral writes.
- RDATA holds its value until the next completed read.
- Requester rules:
  - A requester keeps REQx high until it sees DONEx.
  - If REQx is still high in the IDLE after RESP, it is treated as a new request.
  - Changes to ADDRx/WDATAx/WRx after the grant are ignored.
  - REQx dropped before grant: no transaction occurs.
- Fairness: with both REQs held high continuously, grants alternate 0,1,0,1. Each requester waits at most one transaction (3 cycles) plus its own.
- Reset (any cycle, including mid-XFER or RESP):
  - State goes to IDLE; all outputs 0; RDATA = 0; XFER_CNT = 0.
  - last_owner = 1, so requester 0 wins the first tie.
  - An aborted transaction produces no DONE. Reset does not suppress IOBUS_WR retroactively; because reset is synchronous, the XFER write in the reset cycle still occurs.
- No combinational path from REQx to any output. All outputs are registered or decoded from state.

Decomposition:
- Package iobus_pkg holds:
  - typedef enum {IDLE, XFER, RESP} iobus_state_t
  - the MMIO address constants: SWITCHES_AD = 32'h11000000, LEDS_AD = 32'h11000020, SSEG_AD = 32'h11000040
  - a packed struct iobus_req_t {wr, addr, wdata}
- One sub-module, rr_arb2: a 2-way round-robin arbiter with last_owner state. Inputs: req[1:0], advance. Output: one-hot grant.
- The top level holds the FSM, latches, RDATA and the counter.

Test Plan:
- Single write: REQ0 = 1, WR0 = 1, ADDR0 = 32'h11000020, WDATA0 = 32'h0000A5A5 in cycle 0 -> cycle 1: GNT0 = 1, IOBUS_WR = 1, IOBUS_ADDR = 32'h11000020, IOBUS_OUT = 32'hA5A5; cycle 2: DONE0 = 1, XFER_CNT = 1; IOBUS_WR = 0 in all other cycles.
- Single read: REQ1 = 1, WR1 = 0, ADDR1 = 32'h11000000, IOBUS_IN = 32'h0000BEEF -> GNT1 in cycle 1, IOBUS_WR = 0; cycle 2: DONE1 = 1, RDATA = 32'hBEEF; RDATA still 32'hBEEF 10 cycles later.
- Simultaneous requests after reset, both held: grant order is 0, 1, 0, 1; DONE pulses in cycles 2, 5, 8, 11; XFER_CNT = 4 after cycle 11.
- Late change: ADDR0 changed from 32'h11000040 to 32'h11000020 during XFER -> IOBUS_ADDR stays 32'h11000040.
- Reset mid-op: RST asserted in the RESP cycle of a requester-1 read -> no DONE1 the next cycle, BUSY = 0, XFER_CNT = 0, RDATA = 0; next tie is granted to requester 0.
- Counter wrap: CNT_W = 4, run 16 transactions -> XFER_CNT returns to 0.
